// File: rtl/tqvp_spi_multi_bridge.sv
// SPI-slave register bridge: an external host reads/writes registers on one of
// NCH TinyQV-style peripherals using a single MSB-first frame per access.
module tqvp_spi_multi_bridge #(
  parameter int ADDR_W  = 6,
  parameter int NCH     = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                spi_cs_n,
  input  logic                spi_clk,
  input  logic                spi_mosi,
  output logic                spi_miso,
  output logic [ADDR_W-1:0]   address,
  output logic [31:0]         data_in,
  output logic [1:0]          data_write_n,
  output logic [1:0]          data_read_n,
  output logic [NCH-1:0]      chan_sel,
  input  logic [32*NCH-1:0]   data_out,
  input  logic [NCH-1:0]      data_ready,
  output logic                busy,
  output logic                err_timeout
);

  localparam int CH_W    = $clog2(NCH);
  localparam int HDR_LEN = 3 + CH_W + ADDR_W;
  localparam logic [7:0]  HDR_LAST = 8'(HDR_LEN - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, HDR, WR_DATA, WR_STB, RD_WAIT, RD_SHIFT, DONE} state_t;

  // Header layout in frame order, MSB first.
  typedef struct packed {
    logic              wr;
    logic [1:0]        txn;
    logic [CH_W-1:0]   ch;
    logic [ADDR_W-1:0] addr;
  } hdr_t;

  function automatic logic [5:0] txn_bits(input logic [1:0] t);
    case (t)
      2'b00:   return 6'd8;
      2'b01:   return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  function automatic logic [31:0] txn_mask(input logic [1:0] t);
    case (t)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  state_t                 state;
  logic                   spi_clk_q, cs_q;
  logic [HDR_LEN-2:0]     hdr_sr;
  logic [7:0]             bit_cnt;
  logic [15:0]            wait_cnt;
  logic [1:0]             width;
  logic [CH_W-1:0]        chan;
  logic [31:0]            sr;
  logic                   rd_armed;

  logic                   sclk_rise, sclk_fall, cs_fall;
  hdr_t                   hdr_w;
  logic [NCH-1:0][31:0]   dout_a;
  logic [31:0]            sel_data, rd_ld;
  logic [5:0]             nbits;
  logic [7:0]             n_last;

  assign sclk_rise = spi_clk & ~spi_clk_q;
  assign sclk_fall = ~spi_clk & spi_clk_q;
  assign cs_fall   = cs_q & ~spi_cs_n;
  assign hdr_w     = {hdr_sr, spi_mosi};
  assign dout_a    = data_out;
  assign sel_data  = dout_a[chan];
  assign nbits     = txn_bits(width);
  assign n_last    = {2'b00, nbits} - 8'd1;
  // A timed-out read returns all ones within the transaction width.
  assign rd_ld     = data_ready[chan] ? (sel_data & txn_mask(width)) : txn_mask(width);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      spi_clk_q    <= 1'b0;
      cs_q         <= 1'b1;
      hdr_sr       <= '0;
      bit_cnt      <= '0;
      wait_cnt     <= '0;
      width        <= 2'b11;
      chan         <= '0;
      sr           <= '0;
      rd_armed     <= 1'b0;
      spi_miso     <= 1'b0;
      address      <= '0;
      data_in      <= '0;
      data_write_n <= 2'b11;
      data_read_n  <= 2'b11;
      chan_sel     <= '0;
      err_timeout  <= 1'b0;
    end else begin
      spi_clk_q <= spi_clk;
      cs_q      <= spi_cs_n;
      // CS high aborts any frame; a strobe already on the bus just ends.
      if (state != IDLE && spi_cs_n) begin
        state        <= IDLE;
        chan_sel     <= '0;
        spi_miso     <= 1'b0;
        data_write_n <= 2'b11;
        data_read_n  <= 2'b11;
      end else begin
        case (state)
          IDLE: if (cs_fall) begin
            state       <= HDR;
            bit_cnt     <= '0;
            err_timeout <= 1'b0;
          end
          HDR: if (sclk_rise) begin
            hdr_sr  <= {hdr_sr[HDR_LEN-3:0], spi_mosi};
            bit_cnt <= bit_cnt + 8'd1;
            if (bit_cnt == HDR_LAST) begin
              address  <= hdr_w.addr;
              chan     <= hdr_w.ch;
              width    <= hdr_w.txn;
              chan_sel <= NCH'(1) << hdr_w.ch;
              bit_cnt  <= '0;
              wait_cnt <= '0;
              sr       <= '0;
              rd_armed <= 1'b0;
              if (hdr_w.txn == 2'b11) state <= DONE;
              else if (hdr_w.wr)      state <= WR_DATA;
              else begin
                state       <= RD_WAIT;
                data_read_n <= hdr_w.txn;
              end
            end
          end
          WR_DATA: if (sclk_rise) begin
            sr      <= {sr[30:0], spi_mosi};
            bit_cnt <= bit_cnt + 8'd1;
            if (bit_cnt == n_last) begin
              data_in      <= {sr[30:0], spi_mosi};
              data_write_n <= width;
              state        <= WR_STB;
            end
          end
          WR_STB: begin
            data_write_n <= 2'b11;
            state        <= DONE;
          end
          RD_WAIT: begin
            if (data_ready[chan] || wait_cnt == TO_LAST) begin
              sr          <= rd_ld;
              spi_miso    <= rd_ld[nbits - 6'd1];
              err_timeout <= err_timeout | ~data_ready[chan];
              data_read_n <= 2'b11;
              state       <= RD_SHIFT;
            end else begin
              wait_cnt <= wait_cnt + 16'd1;
            end
          end
          // Only a fall that follows a rise seen in this state advances, so the
          // trailing fall of the last header bit can never skip a data bit.
          RD_SHIFT: begin
            if (sclk_rise) rd_armed <= 1'b1;
            else if (sclk_fall && rd_armed) begin
              rd_armed <= 1'b0;
              if (bit_cnt == n_last) begin
                spi_miso <= 1'b0;
                state    <= DONE;
              end else begin
                bit_cnt  <= bit_cnt + 8'd1;
                sr       <= sr << 1;
                spi_miso <= sr[nbits - 6'd2];
              end
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
